// File: rtl/adc_cfg_pkg.sv
// adc_cfg_pkg
// Shared definitions for the ADC configuration sequencer: the FSM state
// encoding, the layout of one register-table entry and a helper that splits
// a raw table word into its fields.
package adc_cfg_pkg;

    localparam int ENTRY_W    = 22;
    localparam int VERIFY_BIT = 21;
    localparam int ADDR_MSB   = 20;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;
    localparam int REG_ADDR_W = ADDR_MSB - ADDR_LSB + 1;
    localparam int REG_DATA_W = DATA_MSB + 1;

    typedef enum logic [3:0] {
        ST_PWR_WAIT  = 4'd0,
        ST_FETCH     = 4'd1,
        ST_LATCH     = 4'd2,
        ST_WRITE     = 4'd3,
        ST_READ      = 4'd4,
        ST_CHECK     = 4'd5,
        ST_NEXT      = 4'd6,
        ST_HOST_IDLE = 4'd7,
        ST_HOST_XFER = 4'd8,
        ST_ERROR     = 4'd9
    } cfg_state_e;

    typedef struct packed {
        logic                  verify;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } cfg_entry_t;

    // Split a raw ROM word {verify, addr, data} into its fields.
    function automatic cfg_entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        cfg_entry_t e;
        e.verify = raw[VERIFY_BIT];
        e.addr   = raw[ADDR_MSB:ADDR_LSB];
        e.data   = raw[DATA_MSB:0];
        return e;
    endfunction

endpackage

// File: rtl/adc_cfg_rom.sv
// adc_cfg_rom
// Synchronous register-table ROM with a one-cycle read latency. The table
// image is handed in as a flattened parameter (entry i at bits
// [i*ENTRY_W +: ENTRY_W]), produced from the register-table memory file when
// the build generates the instance. Addresses beyond the table read as zero.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   addr       entry index
//   rdata      entry word, valid the cycle after addr
module adc_cfg_rom
    import adc_cfg_pkg::*;
#(
    parameter int                          NUM_REGS = 16,
    parameter logic [NUM_REGS*ENTRY_W-1:0] TABLE    = '0
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         addr,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] rdata_d;
    logic [ENTRY_W-1:0] rdata_q;

    // Select the addressed entry, zero outside the populated table.
    always_comb begin
        rdata_d = {ENTRY_W{1'b0}};
        if (32'(addr) < NUM_REGS) begin
            rdata_d = TABLE[32'(addr) * ENTRY_W +: ENTRY_W];
        end else begin
            rdata_d = {ENTRY_W{1'b0}};
        end
    end

    // Output register providing the one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= {ENTRY_W{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_cfg_seq.sv
// adc_cfg_seq
// Configuration sequencer and sole command source for the ADC SPI register
// controller. After reset it waits PWR_WAIT cycles, then walks the register
// table (one write per entry, optional read-back verify with bounded
// retries). Afterwards it forwards single host register accesses to the
// same controller.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   start                          pulse: re-run the table (HOST_IDLE/ERROR only)
//   tbl_addr / tbl_data            table ROM address / entry word (1-cycle latency)
//   spi_addr_2byte                 constant address-width select
//   cmd_write / cmd_write_ack      write command level / completion pulse
//   write_addr / write_data        write command fields
//   cmd_read / cmd_read_ack        read command level / completion pulse
//   read_addr / read_data          read command address / returned data
//   host_write / host_read         host request levels (held until host_ack)
//   host_addr / host_wdata         host request fields
//   host_ack / host_rdata          host completion pulse / read result
//   busy / done / error / err_idx  table run status
module adc_cfg_seq
    import adc_cfg_pkg::*;
#(
    parameter int          NUM_REGS   = 16,
    parameter logic [19:0] PWR_WAIT   = 20'd50000,
    parameter int          RETRY_MAX  = 3,
    parameter logic        ADDR_2BYTE = 1'b1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  tbl_addr,
    input  logic [21:0] tbl_data,
    output logic        spi_addr_2byte,
    output logic        cmd_write,
    output logic        cmd_read,
    output logic [12:0] write_addr,
    output logic [12:0] read_addr,
    output logic [7:0]  write_data,
    input  logic        cmd_write_ack,
    input  logic        cmd_read_ack,
    input  logic [7:0]  read_data,
    input  logic        host_write,
    input  logic        host_read,
    input  logic [12:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  err_idx
);

    localparam int             RETRY_W   = $clog2(RETRY_MAX) + 1;
    localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);
    localparam logic [7:0]     LAST_IDX  = 8'(NUM_REGS - 1);

    cfg_state_e         state_d,      state_q;
    logic [19:0]        pwr_cnt_d,    pwr_cnt_q;
    logic [7:0]         idx_d,        idx_q;
    logic [RETRY_W-1:0] retry_d,      retry_q;
    cfg_entry_t         entry_d,      entry_q;
    logic               host_wr_d,    host_wr_q;
    logic               host_cap_d,   host_cap_q;
    logic [7:0]         tbl_addr_d,   tbl_addr_q;
    logic               cmd_write_d,  cmd_write_q;
    logic               cmd_read_d,   cmd_read_q;
    logic [12:0]        write_addr_d, write_addr_q;
    logic [12:0]        read_addr_d,  read_addr_q;
    logic [7:0]         write_data_d, write_data_q;
    logic               host_ack_d,   host_ack_q;
    logic [7:0]         host_rdata_d, host_rdata_q;
    logic               busy_d,       busy_q;
    logic               done_d,       done_q;
    logic               error_d,      error_q;
    logic [7:0]         err_idx_d,    err_idx_q;

    cfg_entry_t         tbl_entry_s;
    logic               pwr_done_s;
    logic               retry_more_s;
    logic               host_req_s;

    assign tbl_entry_s  = unpack_entry(tbl_data);
    assign pwr_done_s   = (PWR_WAIT == 20'd0) || (pwr_cnt_q >= (PWR_WAIT - 20'd1));
    assign retry_more_s = (32'(retry_q) < (RETRY_MAX - 1));
    // While host_ack is high the host is still allowed to hold its request,
    // so only a request seen after that cycle counts as a new transaction.
    assign host_req_s   = !host_ack_q && (host_write || host_read);

    // Next-state and registered-output computation for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        idx_d        = idx_q;
        retry_d      = retry_q;
        entry_d      = entry_q;
        host_wr_d    = host_wr_q;
        host_cap_d   = host_cap_q;
        tbl_addr_d   = tbl_addr_q;
        cmd_write_d  = cmd_write_q;
        cmd_read_d   = cmd_read_q;
        write_addr_d = write_addr_q;
        read_addr_d  = read_addr_q;
        write_data_d = write_data_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        err_idx_d    = err_idx_q;

        case (state_q)
            ST_PWR_WAIT: begin
                if (pwr_done_s) begin
                    idx_d      = 8'd0;
                    tbl_addr_d = 8'd0;
                    state_d    = ST_FETCH;
                end else begin
                    pwr_cnt_d  = pwr_cnt_q + 20'd1;
                end
            end
            ST_FETCH: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                // Issue the write in the same step so cmd_write is registered.
                entry_d      = tbl_entry_s;
                retry_d      = {RETRY_W{1'b0}};
                cmd_write_d  = 1'b1;
                write_addr_d = tbl_entry_s.addr;
                write_data_d = tbl_entry_s.data;
                state_d      = ST_WRITE;
            end
            ST_WRITE: begin
                if (cmd_write_ack) begin
                    cmd_write_d = 1'b0;
                    if (entry_q.verify) begin
                        cmd_read_d  = 1'b1;
                        read_addr_d = entry_q.addr;
                        state_d     = ST_READ;
                    end else begin
                        state_d     = ST_NEXT;
                    end
                end else begin
                    cmd_write_d = 1'b1;
                end
            end
            ST_READ: begin
                if (cmd_read_ack) begin
                    cmd_read_d = 1'b0;
                    state_d    = ST_CHECK;
                end else begin
                    cmd_read_d = 1'b1;
                end
            end
            ST_CHECK: begin
                // read_data is valid here: this is the cycle after the ack.
                if (read_data == entry_q.data) begin
                    state_d = ST_NEXT;
                end else if (retry_more_s) begin
                    retry_d      = retry_q + RETRY_ONE;
                    cmd_write_d  = 1'b1;
                    write_addr_d = entry_q.addr;
                    write_data_d = entry_q.data;
                    state_d      = ST_WRITE;
                end else begin
                    error_d   = 1'b1;
                    busy_d    = 1'b0;
                    err_idx_d = idx_q;
                    state_d   = ST_ERROR;
                end
            end
            ST_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_HOST_IDLE;
                end else begin
                    idx_d      = idx_q + 8'd1;
                    tbl_addr_d = idx_q + 8'd1;
                    state_d    = ST_FETCH;
                end
            end
            ST_HOST_IDLE, ST_ERROR: begin
                // A host request wins over a simultaneous start.
                if (host_req_s) begin
                    host_cap_d = 1'b0;
                    state_d    = ST_HOST_XFER;
                    if (host_write) begin
                        host_wr_d    = 1'b1;
                        cmd_write_d  = 1'b1;
                        write_addr_d = host_addr;
                        write_data_d = host_wdata;
                    end else begin
                        host_wr_d    = 1'b0;
                        cmd_read_d   = 1'b1;
                        read_addr_d  = host_addr;
                    end
                end else if (start) begin
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    idx_d      = 8'd0;
                    tbl_addr_d = 8'd0;
                    state_d    = ST_FETCH;
                end else begin
                    state_d    = state_q;
                end
            end
            ST_HOST_XFER: begin
                if (host_wr_q) begin
                    if (cmd_write_ack) begin
                        cmd_write_d = 1'b0;
                        host_ack_d  = 1'b1;
                        state_d     = ST_HOST_IDLE;
                    end else begin
                        cmd_write_d = 1'b1;
                    end
                end else if (host_cap_q) begin
                    // read_data only becomes valid the cycle after the ack,
                    // so the result is captured one step later.
                    host_cap_d   = 1'b0;
                    host_rdata_d = read_data;
                    host_ack_d   = 1'b1;
                    state_d      = ST_HOST_IDLE;
                end else if (cmd_read_ack) begin
                    cmd_read_d = 1'b0;
                    host_cap_d = 1'b1;
                end else begin
                    cmd_read_d = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: drop commands and restart cleanly.
                cmd_write_d = 1'b0;
                cmd_read_d  = 1'b0;
                busy_d      = 1'b1;
                pwr_cnt_d   = 20'd0;
                state_d     = ST_PWR_WAIT;
            end
        endcase
    end

    // State and output registers; reset aborts any command immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_PWR_WAIT;
            pwr_cnt_q    <= 20'd0;
            idx_q        <= 8'd0;
            retry_q      <= {RETRY_W{1'b0}};
            entry_q      <= '0;
            host_wr_q    <= 1'b0;
            host_cap_q   <= 1'b0;
            tbl_addr_q   <= 8'd0;
            cmd_write_q  <= 1'b0;
            cmd_read_q   <= 1'b0;
            write_addr_q <= 13'd0;
            read_addr_q  <= 13'd0;
            write_data_q <= 8'd0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 8'd0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_idx_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            idx_q        <= idx_d;
            retry_q      <= retry_d;
            entry_q      <= entry_d;
            host_wr_q    <= host_wr_d;
            host_cap_q   <= host_cap_d;
            tbl_addr_q   <= tbl_addr_d;
            cmd_write_q  <= cmd_write_d;
            cmd_read_q   <= cmd_read_d;
            write_addr_q <= write_addr_d;
            read_addr_q  <= read_addr_d;
            write_data_q <= write_data_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_idx_q    <= err_idx_d;
        end
    end

    assign spi_addr_2byte = ADDR_2BYTE;
    assign tbl_addr       = tbl_addr_q;
    assign cmd_write      = cmd_write_q;
    assign cmd_read       = cmd_read_q;
    assign write_addr     = write_addr_q;
    assign read_addr      = read_addr_q;
    assign write_data     = write_data_q;
    assign host_ack       = host_ack_q;
    assign host_rdata     = host_rdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_idx        = err_idx_q;

endmodule

// File: tb/tb_adc_cfg_seq.sv
// tb_adc_cfg_seq
// Directed self-checking bench for adc_cfg_seq with a small SPI controller
// model (fixed ack latency, register memory, optional stuck-at-zero reads)
// and two table ROMs selected by tbl_sel.
module tb_adc_cfg_seq;
    import adc_cfg_pkg::*;

    localparam int NREG = 3;
    localparam logic [NREG*ENTRY_W-1:0] TBL_A = {
        {1'b0, 13'h0FF, 8'h01},
        {1'b0, 13'h008, 8'h03},
        {1'b0, 13'h014, 8'h01}
    };
    localparam logic [NREG*ENTRY_W-1:0] TBL_B = {
        {1'b0, 13'h008, 8'h03},
        {1'b0, 13'h014, 8'h01},
        {1'b1, 13'h018, 8'h0A}
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  tbl_addr;
    logic [21:0] tbl_data;
    logic [21:0] rom_a_data;
    logic [21:0] rom_b_data;
    logic        tbl_sel = 1'b0;
    logic        spi_addr_2byte;
    logic        cmd_write;
    logic        cmd_read;
    logic [12:0] write_addr;
    logic [12:0] read_addr;
    logic [7:0]  write_data;
    logic        cmd_write_ack;
    logic        cmd_read_ack;
    logic [7:0]  read_data;
    logic        host_write = 1'b0;
    logic        host_read = 1'b0;
    logic [12:0] host_addr = 13'h0;
    logic [7:0]  host_wdata = 8'h0;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  err_idx;

    int checks = 0;
    int failures = 0;

    // SPI model state
    logic        stuck = 1'b0;
    logic [1:0]  lat_cnt;
    logic [12:0] rd_addr_lat;
    logic [7:0]  mem [8192];
    logic [12:0] wr_log_addr [128];
    logic [7:0]  wr_log_data [128];
    logic [12:0] rd_log_addr [128];
    int          n_wr = 0;
    int          n_rd = 0;
    int          overlap_cnt = 0;
    int          drop_cnt = 0;
    logic        wr_prev, rd_prev, wr_ack_prev, rd_ack_prev;

    always #5 clk = ~clk;

    adc_cfg_rom #(.NUM_REGS(NREG), .TABLE(TBL_A)) u_rom_a (
        .clk(clk), .rst(rst), .addr(tbl_addr), .rdata(rom_a_data));
    adc_cfg_rom #(.NUM_REGS(NREG), .TABLE(TBL_B)) u_rom_b (
        .clk(clk), .rst(rst), .addr(tbl_addr), .rdata(rom_b_data));
    assign tbl_data = tbl_sel ? rom_b_data : rom_a_data;

    adc_cfg_seq #(
        .NUM_REGS(NREG), .PWR_WAIT(20'd10), .RETRY_MAX(3), .ADDR_2BYTE(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .spi_addr_2byte(spi_addr_2byte),
        .cmd_write(cmd_write), .cmd_read(cmd_read),
        .write_addr(write_addr), .read_addr(read_addr), .write_data(write_data),
        .cmd_write_ack(cmd_write_ack), .cmd_read_ack(cmd_read_ack),
        .read_data(read_data),
        .host_write(host_write), .host_read(host_read),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata),
        .busy(busy), .done(done), .error(error), .err_idx(err_idx)
    );

    // SPI controller model: ack after 4 cycles, logs each completed command.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_write_ack <= 1'b0;
            cmd_read_ack  <= 1'b0;
            read_data     <= 8'h00;
            lat_cnt       <= 2'd0;
            rd_addr_lat   <= 13'h0;
            wr_prev       <= 1'b0;
            rd_prev       <= 1'b0;
            wr_ack_prev   <= 1'b0;
            rd_ack_prev   <= 1'b0;
        end else begin
            cmd_write_ack <= 1'b0;
            cmd_read_ack  <= 1'b0;
            if (cmd_write && !cmd_write_ack) begin
                if (lat_cnt == 2'd3) begin
                    cmd_write_ack <= 1'b1;
                    lat_cnt       <= 2'd0;
                    mem[write_addr] <= write_data;
                    if (n_wr < 128) begin
                        wr_log_addr[n_wr] <= write_addr;
                        wr_log_data[n_wr] <= write_data;
                    end
                    n_wr <= n_wr + 1;
                end else begin
                    lat_cnt <= lat_cnt + 2'd1;
                end
            end else if (cmd_read && !cmd_read_ack) begin
                if (lat_cnt == 2'd3) begin
                    cmd_read_ack <= 1'b1;
                    lat_cnt      <= 2'd0;
                    read_data    <= 8'hEE;
                    rd_addr_lat  <= read_addr;
                    if (n_rd < 128) rd_log_addr[n_rd] <= read_addr;
                    n_rd <= n_rd + 1;
                end else begin
                    lat_cnt <= lat_cnt + 2'd1;
                end
            end
            if (cmd_read_ack) begin
                read_data <= stuck ? 8'h00 :
                             (rd_addr_lat == 13'h001) ? 8'h9A : mem[rd_addr_lat];
            end
            if (cmd_write && cmd_read) overlap_cnt <= overlap_cnt + 1;
            if (wr_prev && !cmd_write && !wr_ack_prev) drop_cnt <= drop_cnt + 1;
            if (rd_prev && !cmd_read && !rd_ack_prev) drop_cnt <= drop_cnt + 1;
            wr_prev     <= cmd_write;
            rd_prev     <= cmd_read;
            wr_ack_prev <= cmd_write_ack;
            rd_ack_prev <= cmd_read_ack;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_write, cmd_read, host_ack, done, error, busy} !== 6'b000001) begin
            $display("FAIL reset_flags got=%b exp=000001", {cmd_write, cmd_read, host_ack, done, error, busy});
            failures++;
        end
        checks++;
        if ({tbl_addr, err_idx, host_rdata} !== 24'h0) begin
            $display("FAIL reset_idx_rdata got=%h exp=000000", {tbl_addr, err_idx, host_rdata});
            failures++;
        end
        checks++;
        if ({write_addr, read_addr, write_data} !== 34'h0) begin
            $display("FAIL reset_cmd_fields got=%h exp=0", {write_addr, read_addr, write_data});
            failures++;
        end
        checks++;
        if (spi_addr_2byte !== 1'b1) begin
            $display("FAIL addr_2byte got=%b exp=1", spi_addr_2byte);
            failures++;
        end
    endtask

    task automatic test_table_plain();
        int wr0 = n_wr;
        int rd0 = n_rd;
        int cyc = 0;
        tbl_sel = 1'b0;
        rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            cyc = i;
            if (cmd_write) break;
        end
        checks++;
        if (cyc != 12) begin
            $display("FAIL pwr_wait_latency got=%0d exp=12", cyc);
            failures++;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) break;
        end
        checks++;
        if ({done, busy, error} !== 3'b100) begin
            $display("FAIL plain_status got=%b exp=100", {done, busy, error});
            failures++;
        end
        checks++;
        if ((n_wr - wr0) != 3 || (n_rd - rd0) != 0) begin
            $display("FAIL plain_counts got_wr=%0d got_rd=%0d exp_wr=3 exp_rd=0", n_wr - wr0, n_rd - rd0);
            failures++;
        end
        for (int k = 0; k < 3; k++) begin
            logic [20:0] exp_w;
            exp_w = (k == 0) ? {13'h014, 8'h01} : (k == 1) ? {13'h008, 8'h03} : {13'h0FF, 8'h01};
            checks++;
            if ({wr_log_addr[wr0 + k], wr_log_data[wr0 + k]} !== exp_w) begin
                $display("FAIL plain_write%0d got=%h exp=%h", k, {wr_log_addr[wr0 + k], wr_log_data[wr0 + k]}, exp_w);
                failures++;
            end
        end
    endtask

    task automatic test_host_pending();
        int wr0 = n_wr;
        int rd0 = n_rd;
        bit early = 1'b0;
        bit got = 1'b0;
        pulse_start();
        host_read = 1'b1;
        host_addr = 13'h001;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got = 1'b1;
                if (busy || !done) early = 1'b1;
                break;
            end
        end
        checks++;
        if (!got || early) begin
            $display("FAIL host_pending_ack got_ack=%b early=%b exp_ack=1 exp_early=0", got, early);
            failures++;
        end
        checks++;
        if (host_rdata !== 8'h9A) begin
            $display("FAIL host_rdata got=%h exp=9a", host_rdata);
            failures++;
        end
        host_read = 1'b0;
        checks++;
        if ((n_rd - rd0) != 1 || rd_log_addr[rd0] !== 13'h001 || (n_wr - wr0) != 3) begin
            $display("FAIL host_read_cmds got_rd=%0d got_addr=%h got_wr=%0d exp=1/001/3", n_rd - rd0, rd_log_addr[rd0], n_wr - wr0);
            failures++;
        end
        @(negedge clk);
        checks++;
        if (host_ack !== 1'b0) begin
            $display("FAIL host_ack_pulse got=%b exp=0", host_ack);
            failures++;
        end
    endtask

    task automatic test_start_vs_host();
        int wr0 = n_wr;
        int ack_cyc = -1;
        int hack_cyc = -1;
        bit busy_seen = 1'b0;
        @(negedge clk);
        host_write = 1'b1;
        host_addr  = 13'h0FF;
        host_wdata = 8'h01;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (busy) busy_seen = 1'b1;
            if (cmd_write_ack) ack_cyc = i;
            if (host_ack) begin
                hack_cyc = i;
                break;
            end
            @(negedge clk);
        end
        host_write = 1'b0;
        checks++;
        if (hack_cyc < 0 || hack_cyc != ack_cyc + 1) begin
            $display("FAIL host_write_ack_timing got_ack=%0d got_hack=%0d exp_hack=ack+1", ack_cyc, hack_cyc);
            failures++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (busy_seen || done !== 1'b1) begin
            $display("FAIL start_ignored got_busy=%b got_done=%b exp=0/1", busy_seen, done);
            failures++;
        end
        checks++;
        if ((n_wr - wr0) != 1 || {wr_log_addr[wr0], wr_log_data[wr0]} !== {13'h0FF, 8'h01}) begin
            $display("FAIL host_write_cmd got_n=%0d got=%h exp=1/%h", n_wr - wr0, {wr_log_addr[wr0], wr_log_data[wr0]}, {13'h0FF, 8'h01});
            failures++;
        end
    endtask

    task automatic test_verify_ok();
        int wr0 = n_wr;
        int rd0 = n_rd;
        tbl_sel = 1'b1;
        stuck = 1'b0;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checks++;
        if ({done, error, busy} !== 3'b100) begin
            $display("FAIL verify_ok_status got=%b exp=100", {done, error, busy});
            failures++;
        end
        checks++;
        if ((n_wr - wr0) != 3 || {wr_log_addr[wr0], wr_log_data[wr0]} !== {13'h018, 8'h0A}) begin
            $display("FAIL verify_ok_writes got_n=%0d got0=%h exp=3/%h", n_wr - wr0, {wr_log_addr[wr0], wr_log_data[wr0]}, {13'h018, 8'h0A});
            failures++;
        end
        checks++;
        if ((n_rd - rd0) != 1 || rd_log_addr[rd0] !== 13'h018) begin
            $display("FAIL verify_ok_reads got_n=%0d got_addr=%h exp=1/018", n_rd - rd0, rd_log_addr[rd0]);
            failures++;
        end
    endtask

    task automatic test_verify_fail();
        int wr0 = n_wr;
        int rd0 = n_rd;
        int n018 = 0;
        tbl_sel = 1'b1;
        stuck = 1'b1;
        pulse_start();
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        checks++;
        if ({done, error, busy} !== 3'b010 || err_idx !== 8'd0) begin
            $display("FAIL verify_fail_status got=%b idx=%0d exp=010 idx=0", {done, error, busy}, err_idx);
            failures++;
        end
        for (int k = 0; k < 3; k++) begin
            if (wr_log_addr[wr0 + k] == 13'h018 && rd_log_addr[rd0 + k] == 13'h018) n018++;
        end
        checks++;
        if ((n_wr - wr0) != 3 || (n_rd - rd0) != 3 || n018 != 3) begin
            $display("FAIL verify_fail_retries got_wr=%0d got_rd=%0d got_pairs=%0d exp=3/3/3", n_wr - wr0, n_rd - rd0, n018);
            failures++;
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid();
        int wr0;
        int cyc = 0;
        tbl_sel = 1'b0;
        pulse_start();
        checks++;
        if ({error, busy} !== 2'b01) begin
            $display("FAIL start_from_error got=%b exp=01", {error, busy});
            failures++;
        end
        for (int i = 0; i < 50; i++) begin
            if (cmd_write) break;
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_write, cmd_read, busy} !== 3'b001) begin
            $display("FAIL reset_mid_abort got=%b exp=001", {cmd_write, cmd_read, busy});
            failures++;
        end
        @(negedge clk);
        checks++;
        if ({cmd_write, cmd_read, busy, done} !== 4'b0010) begin
            $display("FAIL reset_mid_hold got=%b exp=0010", {cmd_write, cmd_read, busy, done});
            failures++;
        end
        wr0 = n_wr;
        rst = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            cyc = i;
            if (cmd_write) break;
        end
        checks++;
        if (cyc != 12 || write_addr !== 13'h014) begin
            $display("FAIL reset_mid_restart got_cyc=%0d got_addr=%h exp=12/014", cyc, write_addr);
            failures++;
        end
        for (int i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || (n_wr - wr0) != 3 || wr_log_addr[wr0] !== 13'h014) begin
            $display("FAIL reset_mid_rerun got_done=%b got_n=%0d got_addr=%h exp=1/3/014", done, n_wr - wr0, wr_log_addr[wr0]);
            failures++;
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (overlap_cnt != 0 || drop_cnt != 0) begin
            $display("FAIL cmd_protocol got_overlap=%0d got_drop=%0d exp=0/0", overlap_cnt, drop_cnt);
            failures++;
        end
    endtask

    initial begin
        test_reset();
        test_table_plain();
        test_host_pending();
        test_start_vs_host();
        test_verify_ok();
        test_verify_fail();
        test_reset_mid();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
